// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and the MEM stage.
// Optional fetch anti-starvation streak limit is enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  input  logic [2:0]        d_func3,
  output logic              d_ready,
  output logic              d_valid,
  output logic [63:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_port_d;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [63:0]        r_wdata;
  logic [2:0]         r_func3;
  logic [2:0]         r_cnt;
  logic [31:0]        r_if_rdata;
  logic [63:0]        r_d_rdata;

  logic w_can_accept;
  logic w_fetch_pri;
  logic w_grant_d;
  logic w_grant_i;
  logic w_acc_d;
  logic w_acc_i;
  logic w_accept;
  logic w_last;

  assign w_can_accept = (r_state == IDLE) || (r_state == RESP);

`ifdef ARB_FAIRNESS_EN
  logic [2:0] r_streak;

  assign w_fetch_pri = if_req && (r_streak == 3'(STREAK_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (w_acc_i) begin
      r_streak <= '0;
    end else if (w_acc_d && if_req && (r_streak != 3'(STREAK_MAX))) begin
      r_streak <= r_streak + 3'd1;
    end
  end
`else
  // STREAK_MAX is legal only in 1..7, so fetch never gets priority here.
  assign w_fetch_pri = (STREAK_MAX == 0);
`endif

  assign w_grant_d = d_req && !w_fetch_pri;
  assign w_grant_i = if_req && !w_grant_d;

  // Gated by reset so no ready is visible while reset is held.
  assign d_ready  = reset && w_can_accept && w_grant_d;
  assign if_ready = reset && w_can_accept && w_grant_i;

  assign w_acc_d  = d_req && d_ready;
  assign w_acc_i  = if_req && if_ready;
  assign w_accept = w_acc_d || w_acc_i;
  assign w_last   = (r_cnt == 3'(MEM_LAT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ISSUE : IDLE;
      RESP:    w_next = w_accept ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_last ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_d <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_func3  <= '0;
    end else if (w_accept) begin
      r_port_d <= w_acc_d;
      r_we     <= w_acc_d && d_we;
      r_addr   <= w_acc_d ? d_addr : if_addr;
      r_wdata  <= w_acc_d ? d_wdata : '0;
      r_func3  <= w_acc_d ? d_func3 : 3'b010;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= w_last ? '0 : r_cnt + 3'd1;
    end
  end

  // Store completions leave d_rdata untouched; each port holds its last read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if ((r_state == WAIT) && w_last) begin
      if (!r_port_d) begin
        r_if_rdata <= mem_rdata[31:0];
      end else if (!r_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (r_state == ISSUE);
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = mem_en ? r_addr : '0;
  assign mem_wdata = mem_en ? r_wdata : '0;
  assign mem_func3 = mem_en ? r_func3 : '0;

  assign if_valid = (r_state == RESP) && !r_port_d;
  assign d_valid  = (r_state == RESP) && r_port_d;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign busy     = (r_state != IDLE);

endmodule
